// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
//   Bit-serial adder/subtractor. One full adder/subtractor cell processes one
//   bit pair per clock, LSB first. An operation is accepted in IDLE, runs for
//   WIDTH cycles in RUN, and reports its result with a one-cycle DONE pulse.
//
// Parameters
//   WIDTH      operand/result width in bits (1..32)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      begin an operation (only honoured in IDLE)
//   op         0 = a+b, 1 = a-b (latched with start)
//   a, b       operands (latched with start, don't-care afterwards)
//   busy       high while bits are being processed (RUN)
//   done       one-cycle pulse when result is valid
//   result     sum/difference, held until the next accepted start
//   carry_out  add: final carry, sub: final borrow (a < b unsigned)
//   overflow   signed overflow of the operation
//
// Build option
//   ADDSUB_OVERFLOW_EN  when defined, overflow is computed at the MSB and held
//                       with result; otherwise the port is tied to 0 and no
//                       overflow flop exists.

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             op_r;
  logic             carry_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       cell_s;
  logic             bit_res_s;
  logic             bit_carry_s;
  logic             last_bit_s;

  // The single full adder/subtractor cell.
  // Returns {res, carry_out, sub_res, sub_carry}; sub_carry is the borrow.
  function automatic logic [3:0] addsub_cell(input logic x, input logic y, input logic cin);
    logic res;
    logic co;
    logic sres;
    logic sco;
    res  = x ^ y ^ cin;
    co   = (x & y) | (cin & (x ^ y));
    sres = x ^ y ^ cin;
    sco  = (~x & y) | (cin & ~(x ^ y));
    return {res, co, sres, sco};
  endfunction

  // Evaluate the cell on the current bit pair and pick the add or sub outputs.
  always_comb begin
    cell_s      = addsub_cell(a_r[count_r], b_r[count_r], carry_r);
    last_bit_s  = (count_r == LAST_BIT);
    bit_res_s   = cell_s[3];
    bit_carry_s = cell_s[2];
    if (op_r) begin
      bit_res_s   = cell_s[1];
      bit_carry_s = cell_s[0];
    end else begin
      bit_res_s   = cell_s[3];
      bit_carry_s = cell_s[2];
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

`ifdef ADDSUB_OVERFLOW_EN
  logic overflow_r;

  // Overflow flag: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      overflow_r <= 1'b0;
    end else if ((state_r == RUN) && last_bit_s) begin
      overflow_r <= carry_r ^ bit_carry_s;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

  // Datapath: operand latch, serial bit processing, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 1'b0;
      carry_r     <= 1'b0;
      count_r     <= {CW{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r         <= a;
            b_r         <= b;
            op_r        <= op;
            carry_r     <= 1'b0;
            count_r     <= {CW{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
          end
        end
        RUN: begin
          result_r[count_r] <= bit_res_s;
          carry_r           <= bit_carry_s;
          if (last_bit_s) begin
            // Counter parks on the last bit rather than wrapping.
            carry_out_r <= bit_carry_s;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start.
REQ-006 SHALL have port a  input  WIDTH  first operand; latched with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; latched with start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port result  output  WIDTH  sum/difference, held until next accepted start.
REQ-011 SHALL have port carry_out  output  1  add: final carry; sub: final borrow (1 when a<b unsigned).
REQ-012 SHALL have port overflow  output  1  signed two's-complement overflow of the operation.

Function
REQ-013 SHALL use exactly one 1-bit full adder/subtractor cell (a, b, carry_in -> res, carry_out, sub_res, sub_carry), evaluated once per cycle on one bit pair.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 at edge k latches a, b, op; clears carry/borrow flop to 0; clears bit counter to 0; clears result; enters RUN.
REQ-016 IDLE: start=0 SHALL hold state and all outputs.
REQ-017 RUN: at each edge k+1..k+WIDTH, bit i=counter (LSB first) SHALL be processed: result[i] gets res (add) or sub_res (sub); carry flop gets carry_out or sub_carry; counter increments.
REQ-018 RUN SHALL exit to DONE at the edge processing bit WIDTH-1 (edge k+WIDTH); counter SHALL not wrap past WIDTH-1.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
REQ-021 busy SHALL be 1 exactly in RUN; busy and done SHALL never be high together.
REQ-022 start in RUN or DONE SHALL be ignored (no re-latch, no queueing); back-to-back ops need start in IDLE, minimum period WIDTH+2 cycles.
REQ-023 Operand inputs SHALL be don't-care after the start cycle; changes during RUN SHALL not affect result.
REQ-024 carry_out SHALL equal the carry flop after bit WIDTH-1 and be held with result.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst=1 at any edge, including mid-RUN, SHALL force IDLE, counter 0, carry flop 0, busy 0, done 0, result 0, carry_out 0, overflow 0; the in-flight operation is discarded.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro ADDSUB_OVERFLOW_EN: defined -> overflow computed at bit WIDTH-1 as carry into MSB XOR carry out of MSB (add) / borrow into MSB XOR borrow out of MSB (sub), held with result.
REQ-029 ADDSUB_OVERFLOW_EN undefined -> overflow port present but tied 0; no extra state flops.

Verification (WIDTH=8 unless noted)
REQ-030 add 200+100 -> done at cycle 9 after start; result 44, carry_out 1, overflow 0.
REQ-031 sub 5-7 -> result 254, carry_out 1 (borrow); sub 7-5 -> result 2, carry_out 0.
REQ-032 macro defined: add 127+1 -> result 128, overflow 1; sub 128-1 -> result 127, overflow 1; macro undefined: both overflow 0.
REQ-033 start pulsed again 3 cycles into RUN with different operands -> ignored; first result unchanged, single done pulse.
REQ-034 rst asserted 4 cycles into RUN -> next cycle busy 0, result 0, IDLE; following start 1+1 -> result 2.
REQ-035 WIDTH=1: add 1+1 -> done 2 cycles after start, result 0, carry_out 1; sweep all 8 (a,b,op) combos vs. truth table.
